// File: rtl/icache_responder_pkg.sv
// Shared word-width defines, FSM encodings and small types for the icache responder.
// Defines sit outside the package so every file of the slice sees the same word width.
`ifndef ICACHE_RESPONDER_DEFINES
`define ICACHE_RESPONDER_DEFINES
`define WORD_WIDTH   32
`define ZERO_WORD    '0
`define ICR_ST_IDLE  1'b0
`define ICR_ST_WAIT  1'b1
`endif

package icache_responder_pkg;

  typedef enum logic {
    ST_IDLE = `ICR_ST_IDLE,
    ST_WAIT = `ICR_ST_WAIT
  } icr_state_e;

endpackage

// File: rtl/icache_line_array.sv
// Direct-mapped one-word line storage: valid/tag/data with async read and sync write.
// Only the valid bits are cleared; tag and data are don't-care while invalid.
module icache_line_array #(
  parameter int W     = 32,
  parameter int LINES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 26
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [W-1:0]     rd_data_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [W-1:0]     wr_data_i
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [W-1:0]     data_q [LINES];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_responder.sv
// Blocking direct-mapped instruction cache responder: same-cycle hits, one
// outstanding line fill to backing memory, invalidate-all and a miss counter.
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter int W     = `WORD_WIDTH,
  parameter int LINES = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] pc_i,
  output logic [W-1:0] inst_o,
  output logic         stall_req_o,
  output logic         misalign_o,
  input  logic         inv_i,
  output logic         mem_req_o,
  output logic [W-1:0] mem_addr_o,
  input  logic         mem_ack_i,
  input  logic [W-1:0] mem_data_i,
  output logic [W-1:0] miss_count_o
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = W - 2 - IDX_W;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  icr_state_e       state_q;
  logic             mem_req_q;
  logic [W-1:0]     mem_addr_q;
  logic [W-1:0]     miss_count_q;
  logic [IDX_W-1:0] fill_idx_q;
  logic [TAG_W-1:0] fill_tag_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             aligned;
  logic             line_valid;
  logic [TAG_W-1:0] line_tag;
  logic [W-1:0]     line_data;
  logic             hit;
  logic             fill_we;
  logic             arr_clr;

  assign idx     = pc_i[2+IDX_W-1:2];
  assign tag     = pc_i[W-1:2+IDX_W];
  assign aligned = (pc_i[1:0] == 2'b00);
  assign hit     = (state_q == ST_IDLE) && aligned && line_valid && (line_tag == tag);

  // An invalidate landing with the ack drops the fill; reset abandons it.
  assign fill_we = (state_q == ST_WAIT) && mem_ack_i && !inv_i && !rst_i;
  assign arr_clr = rst_i || inv_i;

  icache_line_array #(
    .W     (W),
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_lines (
    .clk_i      (clk_i),
    .clr_i      (arr_clr),
    .rd_idx_i   (idx),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data),
    .we_i       (fill_we),
    .wr_idx_i   (fill_idx_q),
    .wr_tag_i   (fill_tag_q),
    .wr_data_i  (mem_data_i)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= `ZERO_WORD;
      miss_count_q <= `ZERO_WORD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (aligned && !hit) begin
            fill_idx_q <= idx;
            fill_tag_q <= tag;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {pc_i[W-1:2], 2'b00};
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_ack_i) begin
            mem_req_q    <= 1'b0;
            miss_count_q <= miss_count_q + ONE;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Misaligned fetches are reported without stalling, even while a fill is in flight.
  always_comb begin
    inst_o      = `ZERO_WORD;
    stall_req_o = 1'b0;
    misalign_o  = 1'b0;
    if (!rst_i) begin
      if (!aligned) begin
        misalign_o = 1'b1;
      end else if (hit) begin
        inst_o = line_data;
      end else begin
        stall_req_o = 1'b1;
      end
    end
  end

  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign miss_count_o = miss_count_q;

endmodule
